// File: rtl/display_layer_sequencer.sv
// Per-frame layer sequencer: lives, play/blink/game-over state, freeze and relaunch control,
// and tear-free draw enables for the ball, the hearts and the Game Over overlay.
module display_layer_sequencer #(
    parameter int LIVES         = 3,
    parameter int BLINK_FRAMES  = 8,
    parameter int BLINK_TOGGLES = 6,
    parameter int GO_MIN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startGame,
    input  logic       ballLost,
    output logic       ballEn,
    output logic [2:0] heartEn,
    output logic       gameOverEn,
    output logic       freeze,
    output logic       relaunch,
    output logic [1:0] lives
);

    localparam int FMAX = (BLINK_FRAMES > GO_MIN_FRAMES) ? BLINK_FRAMES : GO_MIN_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int TW   = $clog2(BLINK_TOGGLES + 1);

    localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] GO_MIN     = FW'(GO_MIN_FRAMES);
    localparam logic [FW-1:0] F_SAT      = FW'(FMAX);
    localparam logic [FW-1:0] F_ONE      = FW'(1);
    localparam logic [FW-1:0] F_ZERO     = FW'(0);
    localparam logic [TW-1:0] TOG_LAST   = TW'(BLINK_TOGGLES - 1);
    localparam logic [TW-1:0] TOG_ONE    = TW'(1);
    localparam logic [TW-1:0] TOG_ZERO   = TW'(0);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAY      = 2'd1,
        S_BLINK     = 2'd2,
        S_GAME_OVER = 2'd3
    } state_t;

    // One heart shown per remaining life, Heart1 in bit 0.
    function automatic logic [2:0] heart_mask(input logic [1:0] n);
        logic [2:0] m;
        case (n)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    localparam logic [2:0] HEARTS_FULL = heart_mask(LIVES_INIT);

    state_t        state_r;
    logic [FW-1:0] fcnt_r;
    logic [TW-1:0] tog_r;
    logic [1:0]    lives_r;
    logic          ball_en_r;
    logic [2:0]    heart_en_r;
    logic          go_en_r;
    logic          freeze_r;
    logic          relaunch_r;

    logic          ball_tgt_s;
    logic [2:0]    heart_tgt_s;
    logic          go_tgt_s;

    // Draw-enable targets of the current state; loaded into the outputs only at frame start.
    always_comb begin
        ball_tgt_s  = 1'b0;
        heart_tgt_s = heart_mask(lives_r);
        go_tgt_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                ball_tgt_s = 1'b0;
            end
            S_PLAY: begin
                ball_tgt_s = 1'b1;
            end
            S_BLINK: begin
                // lives_r already holds the new count, so it indexes the lost heart.
                if (tog_r[0] == 1'b0) begin
                    heart_tgt_s = heart_mask(lives_r) | (3'b001 << lives_r);
                end else begin
                    heart_tgt_s = heart_mask(lives_r);
                end
            end
            S_GAME_OVER: begin
                heart_tgt_s = 3'b000;
                go_tgt_s    = 1'b1;
            end
            default: begin
                ball_tgt_s = 1'b0;
            end
        endcase
    end

    // Game FSM with counters, life count and all registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r    <= S_IDLE;
            fcnt_r     <= F_ZERO;
            tog_r      <= TOG_ZERO;
            lives_r    <= LIVES_INIT;
            ball_en_r  <= 1'b0;
            heart_en_r <= HEARTS_FULL;
            go_en_r    <= 1'b0;
            freeze_r   <= 1'b1;
            relaunch_r <= 1'b0;
        end else begin
            relaunch_r <= 1'b0;
            if (startOfFrame) begin
                ball_en_r  <= ball_tgt_s;
                heart_en_r <= heart_tgt_s;
                go_en_r    <= go_tgt_s;
            end
            case (state_r)
                S_IDLE: begin
                    if (startGame) begin
                        state_r    <= S_PLAY;
                        fcnt_r     <= F_ZERO;
                        freeze_r   <= 1'b0;
                        relaunch_r <= 1'b1;
                    end else if (startOfFrame && (fcnt_r != F_SAT)) begin
                        fcnt_r <= fcnt_r + F_ONE;
                    end
                end
                S_PLAY: begin
                    if (ballLost) begin
                        fcnt_r   <= F_ZERO;
                        tog_r    <= TOG_ZERO;
                        freeze_r <= 1'b1;
                        lives_r  <= (lives_r == 2'd0) ? 2'd0 : (lives_r - 2'd1);
                        state_r  <= (lives_r <= 2'd1) ? S_GAME_OVER : S_BLINK;
                    end else if (startOfFrame && (fcnt_r != F_SAT)) begin
                        fcnt_r <= fcnt_r + F_ONE;
                    end
                end
                S_BLINK: begin
                    if (startOfFrame) begin
                        if (fcnt_r == BLINK_LAST) begin
                            fcnt_r <= F_ZERO;
                            if (tog_r == TOG_LAST) begin
                                state_r    <= S_PLAY;
                                tog_r      <= TOG_ZERO;
                                freeze_r   <= 1'b0;
                                relaunch_r <= 1'b1;
                            end else begin
                                tog_r <= tog_r + TOG_ONE;
                            end
                        end else begin
                            fcnt_r <= fcnt_r + F_ONE;
                        end
                    end
                end
                S_GAME_OVER: begin
                    // An early startGame is simply dropped.
                    if (startGame && (fcnt_r == GO_MIN)) begin
                        state_r    <= S_PLAY;
                        fcnt_r     <= F_ZERO;
                        lives_r    <= LIVES_INIT;
                        freeze_r   <= 1'b0;
                        relaunch_r <= 1'b1;
                    end else if (startOfFrame && (fcnt_r != GO_MIN)) begin
                        fcnt_r <= fcnt_r + F_ONE;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    fcnt_r   <= F_ZERO;
                    freeze_r <= 1'b1;
                end
            endcase
        end
    end

    assign ballEn     = ball_en_r;
    assign heartEn    = heart_en_r;
    assign gameOverEn = go_en_r;
    assign freeze     = freeze_r;
    assign relaunch   = relaunch_r;
    assign lives      = lives_r;

endmodule

// File: tb/tb_display_layer_sequencer.sv
// Random-stimulus bench: a frame-counting reference model predicts every output vector,
// a scoreboard queue carries the predictions to an independent monitor.
module tb_display_layer_sequencer;

    localparam int BF     = 8;
    localparam int BT     = 6;
    localparam int GOMIN  = 60;
    localparam int NLIVES = 3;
    localparam int NCYC   = 20000;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       startGame = 1'b0;
    logic       ballLost = 1'b0;
    logic       ballEn;
    logic [2:0] heartEn;
    logic       gameOverEn;
    logic       freeze;
    logic       relaunch;
    logic [1:0] lives;

    display_layer_sequencer #(
        .LIVES(NLIVES), .BLINK_FRAMES(BF), .BLINK_TOGGLES(BT), .GO_MIN_FRAMES(GOMIN)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
        .ballLost(ballLost), .ballEn(ballEn), .heartEn(heartEn), .gameOverEn(gameOverEn),
        .freeze(freeze), .relaunch(relaunch), .lives(lives)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_PLAY, M_BLINK, M_OVER} mstate_e;

    mstate_e    m_st;
    int         m_lives;
    int         m_frames;
    logic       m_ball;
    logic       m_go;
    logic       m_relaunch;
    logic [2:0] m_heart;

    logic [8:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    bit         blink_reset_done = 1'b0;

    function automatic logic [2:0] lives_mask(input int n);
        return 3'((1 << n) - 1);
    endfunction

    task automatic model_reset();
        m_st       = M_IDLE;
        m_lives    = NLIVES;
        m_frames   = 0;
        m_ball     = 1'b0;
        m_go       = 1'b0;
        m_relaunch = 1'b0;
        m_heart    = lives_mask(NLIVES);
    endtask

    function automatic logic [8:0] model_out();
        return {m_ball, m_heart, m_go, (m_st != M_PLAY), m_relaunch, 2'(m_lives)};
    endfunction

    // m_frames counts frame pulses since the current state was entered.
    task automatic model_step(input logic sof, input logic sg, input logic bl);
        m_relaunch = 1'b0;
        if (sof) begin
            m_ball = (m_st == M_PLAY);
            m_go   = (m_st == M_OVER);
            case (m_st)
                M_OVER:  m_heart = 3'b000;
                M_BLINK: m_heart = lives_mask(m_lives) |
                                   ((((m_frames / BF) % 2) == 0) ? 3'(1 << m_lives) : 3'b000);
                default: m_heart = lives_mask(m_lives);
            endcase
        end
        case (m_st)
            M_IDLE: begin
                if (sg) begin m_st = M_PLAY; m_frames = 0; m_relaunch = 1'b1; end
                else if (sof) m_frames++;
            end
            M_PLAY: begin
                if (bl) begin
                    m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
                    m_frames = 0;
                    m_st     = (m_lives == 0) ? M_OVER : M_BLINK;
                end else if (sof) m_frames++;
            end
            M_BLINK: begin
                if (sof) begin
                    m_frames++;
                    if (m_frames == BF * BT) begin m_st = M_PLAY; m_frames = 0; m_relaunch = 1'b1; end
                end
            end
            default: begin
                if (sg && m_frames >= GOMIN) begin
                    m_st = M_PLAY; m_lives = NLIVES; m_frames = 0; m_relaunch = 1'b1;
                end else if (sof) m_frames++;
            end
        endcase
    endtask

    task automatic check_one();
        logic [8:0] e;
        logic [8:0] a;
        e = exp_q.pop_front();
        a = {ballEn, heartEn, gameOverEn, freeze, relaunch, lives};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL outputs t=%0t got=%b want=%b (ballEn,heartEn[3],gameOverEn,freeze,relaunch,lives[2])",
                     $time, a, e);
        end
    endtask

    // Monitor: one prediction per clock edge, plus one right after an asynchronous reset.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check_one();
    end

    always @(negedge resetN) begin
        #1;
        if (exp_q.size() > 0) check_one();
    end

    // Short asynchronous reset pulse between clock edges.
    task automatic do_reset();
        startOfFrame = 1'b0;
        startGame    = 1'b0;
        ballLost     = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        resetN = 1'b0;
        #3;
        resetN = 1'b1;
        model_step(1'b0, 1'b0, 1'b0);
        exp_q.push_back(model_out());
    endtask

    initial begin
        logic sof;
        logic sg;
        logic bl;
        model_reset();
        @(negedge clk);
        do_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (!blink_reset_done && m_st == M_BLINK && m_frames == 20) begin
                blink_reset_done = 1'b1;
                do_reset();
                continue;
            end
            if ($urandom_range(0, 4999) == 0) begin
                do_reset();
                continue;
            end
            sof = ($urandom_range(0, 3) == 0);
            sg  = ($urandom_range(0, 49) == 0);
            bl  = ($urandom_range(0, 59) == 0);
            if (m_st == M_OVER && (m_frames == 30 || m_frames == GOMIN)) sg = 1'b1;
            if (m_st == M_PLAY && sof && ($urandom_range(0, 9) == 0)) bl = 1'b1;
            startOfFrame = sof;
            startGame    = sg;
            ballLost     = bl;
            model_step(sof, sg, bl);
            exp_q.push_back(model_out());
        end
        @(negedge clk);
        startOfFrame = 1'b0;
        startGame    = 1'b0;
        ballLost     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
